// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, data width and baud divisor helper.
package uart_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned UART_IDX_W     = 3;
   localparam int unsigned UART_CNT_W     = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Clocks per bit; valid configurations give 2..65535.
   function automatic int unsigned uart_baud_div(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, flags the last cycle of each bit period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic bit_tick_c_o
);

   logic [UART_CNT_W-1:0] cnt_q, cnt_d;

   assign bit_tick_c_o = (cnt_q == UART_CNT_W'(DIV - 1));

   // Wrap at the end of a bit period, hold at zero while cleared.
   always_comb begin
      cnt_d = cnt_q + UART_CNT_W'(1);
      if (clear_i || bit_tick_c_o) begin
         cnt_d = '0;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Build option: define UART_TX_PARITY_EN to include the even-parity bit (11-bit frames);
// without it frames are 10 bits and DATA goes straight to STOP.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tx_enable,
   input  logic                      tx_start,
   input  logic [UART_DATA_BITS-1:0] tx_data,
   output logic                      tx,
   output logic                      tx_busy,
   output logic                      tx_done
);

   localparam int unsigned BAUD_DIV = uart_baud_div(CLK_FREQ, BAUD_RATE);

   uart_state_e               state_q, state_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [UART_IDX_W-1:0]     idx_q, idx_d;
   logic [UART_IDX_W-1:0]     idx_nxt;
   logic                      bit_tick;
`ifdef UART_TX_PARITY_EN
   logic                      parity_q, parity_d;
`endif

   // Counter is held at zero in IDLE so every frame starts on a fresh bit period.
   uart_baud_gen #(
      .DIV (BAUD_DIV)
   ) u_baud_gen (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (state_q == ST_IDLE),
      .bit_tick_c_o (bit_tick)
   );

   assign idx_nxt = idx_q + UART_IDX_W'(1);

   // Next-state and registered-output logic; tx_d is the line level for the next cycle.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      shift_d = shift_q;
      idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_enable && tx_start) begin
               shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
               parity_d = ^tx_data;
`endif
               busy_d  = 1'b1;
               tx_d    = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               idx_d   = '0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (idx_q == UART_IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = parity_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  idx_d = idx_nxt;
                  tx_d  = shift_q[idx_nxt];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) begin
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               tx_d    = 1'b1;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         shift_q <= '0;
         idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at N=10 clocks per bit.
module tb_uart_tx;

   localparam int unsigned N = 10;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned F = 11;
`else
   localparam int unsigned F = 10;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       tx_enable;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   uart_tx #(
      .CLK_FREQ  (1000),
      .BAUD_RATE (100)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_enable (tx_enable),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   // Expected line bits, index 0 = start bit.
   function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, 1'b1, d, 1'b0};
`endif
   endfunction

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic to_edge(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present a request so it is accepted on the next edge; returns 1 unit past that edge.
   task automatic sync_accept(input logic [7:0] d, input logic hold);
      @(posedge clk);
      #1;
      tx_data  = d;
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) tx_start = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      tx_enable = 1'b1;
      tx_start  = 1'b0;
      tx_data   = 8'h00;
      to_edge(2);
      reset = 1'b0;
      for (int i = 0; i < 50; i++) begin
         to_edge(1);
         checks++;
         if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: tx/busy/done=%b%b%b expected 100", i, tx, tx_busy, tx_done);
         end
      end
   endtask

   task automatic test_frame_a5();
      logic [10:0] exp;
      int pos, tgt;
`ifdef UART_TX_PARITY_EN
      exp = 11'b1_0_10100101_0;
`else
      exp = 11'b1_1_10100101_0;
`endif
      sync_accept(8'hA5, 1'b0);
      checks++;
      if (tx !== 1'b0 || tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL a5_accept: tx/busy=%b%b expected 01", tx, tx_busy);
      end
      pos = 0;
      for (int b = 0; b < F; b++) begin
         tgt = b * N + 5;
         to_edge(tgt - pos);
         pos = tgt;
         checks++;
         if (tx !== exp[b] || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL a5_bit%0d: tx/busy/done=%b%b%b expected %b10", b, tx, tx_busy, tx_done, exp[b]);
         end
      end
      to_edge(F * N - 1 - pos);
      checks++;
      if (tx_done !== 1'b0 || tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL a5_pre_done: done/busy=%b%b expected 01", tx_done, tx_busy);
      end
      to_edge(1);
      checks++;
      if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL a5_done: done/busy/tx=%b%b%b expected 101", tx_done, tx_busy, tx);
      end
      to_edge(1);
      checks++;
      if (tx_done !== 1'b0 || tx !== 1'b1) begin
         errors++;
         $display("FAIL a5_done_pulse: done/tx=%b%b expected 01", tx_done, tx);
      end
   endtask

   task automatic test_ignore_busy();
      logic [10:0] exp;
      int pos, tgt;
      exp = exp_frame(8'h07);
      sync_accept(8'h07, 1'b0);
      pos = 0;
      for (int b = 0; b < F; b++) begin
         tgt = b * N + 5;
         to_edge(tgt - pos);
         pos = tgt;
         checks++;
         if (tx !== exp[b]) begin
            errors++;
            $display("FAIL ign07_bit%0d: tx=%b expected %b", b, tx, exp[b]);
         end
         if (b == 2) begin
            // New request and data while busy, then drop enable mid-frame.
            tx_data  = 8'hFF;
            tx_start = 1'b1;
            to_edge(1);
            pos++;
            tx_start  = 1'b0;
            tx_enable = 1'b0;
         end
      end
`ifdef UART_TX_PARITY_EN
      checks++;
      if (exp[9] !== 1'b1) begin
         errors++;
         $display("FAIL ign07_parity_model: parity=%b expected 1", exp[9]);
      end
`endif
      to_edge(F * N - pos);
      checks++;
      if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL ign07_done: done/busy=%b%b expected 10", tx_done, tx_busy);
      end
      // Enable is low: a request now must not start a frame.
      tx_start = 1'b1;
      for (int i = 0; i < 15; i++) begin
         to_edge(1);
         checks++;
         if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL ign07_idle%0d: tx/busy=%b%b expected 10", i, tx, tx_busy);
         end
      end
      tx_start  = 1'b0;
      tx_enable = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [10:0] exp;
      int pos, tgt;
      exp = exp_frame(8'h01);
      sync_accept(8'h01, 1'b1);
      tx_data = 8'h80;
      pos = 0;
      for (int b = 0; b < F; b++) begin
         tgt = b * N + 5;
         to_edge(tgt - pos);
         pos = tgt;
         checks++;
         if (tx !== exp[b]) begin
            errors++;
            $display("FAIL b2b01_bit%0d: tx=%b expected %b", b, tx, exp[b]);
         end
      end
      to_edge(F * N - pos);
      checks++;
      if (tx_done !== 1'b1 || tx !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done1: done/tx=%b%b expected 11", tx_done, tx);
      end
      to_edge(1);
      tx_start = 1'b0;
      checks++;
      if (tx !== 1'b0 || tx_busy !== 1'b1 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_restart: tx/busy/done=%b%b%b expected 010", tx, tx_busy, tx_done);
      end
      exp = exp_frame(8'h80);
      pos = 0;
      for (int b = 0; b < F; b++) begin
         tgt = b * N + 5;
         to_edge(tgt - pos);
         pos = tgt;
         checks++;
         if (tx !== exp[b]) begin
            errors++;
            $display("FAIL b2b80_bit%0d: tx=%b expected %b", b, tx, exp[b]);
         end
      end
      to_edge(F * N - pos);
      checks++;
      if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done2: done/busy=%b%b expected 10", tx_done, tx_busy);
      end
      to_edge(3);
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_third: tx/busy=%b%b expected 10", tx, tx_busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [10:0] exp;
      int pos, tgt;
      sync_accept(8'h3C, 1'b0);
      to_edge(37);
      reset = 1'b1;
      to_edge(1);
      reset = 1'b0;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: tx/busy/done=%b%b%b expected 100", tx, tx_busy, tx_done);
      end
      for (int i = 0; i < 25; i++) begin
         to_edge(1);
         checks++;
         if (tx !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resume%0d: tx/busy=%b%b expected 10", i, tx, tx_busy);
         end
      end
      exp = exp_frame(8'h3C);
      sync_accept(8'h3C, 1'b0);
      pos = 0;
      for (int b = 0; b < F; b++) begin
         tgt = b * N + 5;
         to_edge(tgt - pos);
         pos = tgt;
         checks++;
         if (tx !== exp[b]) begin
            errors++;
            $display("FAIL rst3c_bit%0d: tx=%b expected %b", b, tx, exp[b]);
         end
      end
      to_edge(F * N - pos);
      checks++;
      if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL rst3c_done: done/busy=%b%b expected 10", tx_done, tx_busy);
      end
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
